// File: rtl/bcd_xs3_serial_conv_if.sv
// Handshake bundle for bcd_xs3_serial_conv: input word channel plus result channel.
// Optional per-digit error mask when BCDX3_ERR_MASK_EN is defined.
interface bcd_xs3_serial_conv_if #(
  parameter int DIGITS = 4
);
  localparam int DW = 4 * DIGITS;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

`ifdef BCDX3_ERR_MASK_EN
  logic [DIGITS-1:0] out_err_mask;

  modport slave (
    input  in_valid, in_data, in_dir, out_ready,
    output in_ready, out_valid, out_data, out_err, out_err_mask
  );
  modport master (
    output in_valid, in_data, in_dir, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_err_mask
  );
`else
  modport slave (
    input  in_valid, in_data, in_dir, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
  modport master (
    output in_valid, in_data, in_dir, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
`endif
endinterface

// File: rtl/bcd_xs3_serial_conv.sv
// Digit-serial bidirectional BCD <-> Excess-3 converter, one digit per cycle, LS digit first.
// Optional feature macro: BCDX3_ERR_MASK_EN adds a per-digit invalid-code mask.
module bcd_xs3_serial_conv #(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bcd_xs3_serial_conv_if.slave      bus,
  output logic                      busy
);
  localparam int DW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_word;
  logic [DW-1:0] r_data;
  logic          r_dir;
  logic [3:0]    w_digit;
  logic [3:0]    w_conv;
  logic          w_bad;
  logic          w_accept;
  logic          w_last;

`ifdef BCDX3_ERR_MASK_EN
  logic [DIGITS-1:0] r_mask;
`else
  logic              r_err;
`endif

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == IW'(DIGITS - 1));

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) w_digit = r_word[4*i +: 4];
    end
  end

  // Invalid digits still wrap modulo 16; they are flagged, never saturated.
  always_comb begin
    if (r_dir) begin
      w_conv = w_digit - 4'd3;
      w_bad  = (w_digit < 4'd3) || (w_digit > 4'd12);
    end else begin
      w_conv = w_digit + 4'd3;
      w_bad  = (w_digit > 4'd9);
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (w_accept) w_next = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (w_last) w_next = HOLD;
      end
      HOLD: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
      r_dir  <= 1'b0;
      r_data <= '0;
`ifdef BCDX3_ERR_MASK_EN
      r_mask <= '0;
`else
      r_err  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_word <= bus.in_data;
      r_dir  <= bus.in_dir;
      r_idx  <= '0;
`ifdef BCDX3_ERR_MASK_EN
      r_mask <= '0;
`else
      r_err  <= 1'b0;
`endif
    end else if (r_state == CONV) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_idx == IW'(i)) begin
          r_data[4*i +: 4] <= w_conv;
`ifdef BCDX3_ERR_MASK_EN
          r_mask[i]        <= w_bad;
`endif
        end
      end
`ifndef BCDX3_ERR_MASK_EN
      r_err <= r_err | w_bad;
`endif
      if (!w_last) r_idx <= r_idx + 1'b1;
    end
  end

  assign bus.out_data = r_data;
`ifdef BCDX3_ERR_MASK_EN
  assign bus.out_err      = |r_mask;
  assign bus.out_err_mask = r_mask;
`else
  assign bus.out_err      = r_err;
`endif

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Self-checking bench for bcd_xs3_serial_conv: directed words, scoreboard queue, backpressure, mid-CONV reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_bcd_xs3_serial_conv;
  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;

  typedef struct {
    logic [DW-1:0]     data;
    logic              err;
    logic [DIGITS-1:0] mask;
  } exp_t;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   errors;
  exp_t sb[$];

  bcd_xs3_serial_conv_if #(.DIGITS(DIGITS)) bus ();

  bcd_xs3_serial_conv #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] d, input logic dir);
    exp_t e;
    logic [3:0] dig;
    e.data = '0;
    e.mask = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = d[4*i +: 4];
      if (dir) begin
        e.data[4*i +: 4] = dig - 4'd3;
        e.mask[i]        = (dig < 4'd3) || (dig > 4'd12);
      end else begin
        e.data[4*i +: 4] = dig + 4'd3;
        e.mask[i]        = (dig > 4'd9);
      end
    end
    e.err = |e.mask;
    return e;
  endfunction

  // Returns at the falling edge right after the accept edge; the expected result is queued.
  task automatic send(input logic [DW-1:0] d, input logic dir);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_dir   = dir;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(model(d, dir));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_dir   = ~dir;
    bus.in_data  = 16'hFFFF;
  endtask

  task automatic recv(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: observed empty queue, expected a pending word", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " out_data"}, 32'(bus.out_data), 32'(e.data));
      check({tag, " out_err"}, 32'(bus.out_err), 32'(e.err));
`ifdef BCDX3_ERR_MASK_EN
      check({tag, " out_err_mask"}, 32'(bus.out_err_mask), 32'(e.mask));
`endif
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready after hs"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int            lat;
    logic          stale;
    exp_t          e;
    logic [DW-1:0] held;

    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data", 32'(bus.out_data), 32'd0);
    check("rst out_err", 32'(bus.out_err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);

    // 1234 BCD->XS3 with latency: out_valid after DIGITS further edges (DIGITS+1 counting the accept edge)
    send(16'h1234, 1'b0);
    check("conv busy", 32'(busy), 32'd1);
    check("conv in_ready", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(DIGITS));
    recv("w1234");

    send(16'h4567, 1'b1); recv("w4567");
    send(16'h9999, 1'b0); recv("w9999");
    send(16'h12A4, 1'b0); recv("w12A4");
    send(16'h1234, 1'b0); recv("clean");
    send(16'h0000, 1'b1); recv("w0000");

    // Backpressure: result held three cycles, new word refused
    send(16'h5678, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e    = sb.pop_front();
    held = e.data;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1111;
    bus.in_dir   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp out_data", 32'(bus.out_data), 32'(held));
      check("bp out_err", 32'(bus.out_err), 32'(e.err));
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp out_valid drop", 32'(bus.out_valid), 32'd0);
    check("bp in_ready", 32'(bus.in_ready), 32'd1);
    check("bp no accept", 32'(busy), 32'd0);

    // Reset while converting digit index 2
    send(16'h1234, 1'b0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst out_data", 32'(bus.out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      stale = stale | bus.out_valid;
    end
    check("no stale output", 32'(stale), 32'd0);
    check("post rst in_ready", 32'(bus.in_ready), 32'd1);
    send(16'h0369, 1'b0); recv("w0369");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
